// File: rtl/rsa_controller.sv
// Control FSM for the RSA square-and-multiply datapath: sequences exponent/modulus loads,
// message initialisation, the multiply/modulo loop and result hand-off. Moore, registered outputs.
module rsa_controller #(
  parameter int MAX_MULT     = 256,
  parameter int INIT_TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic load_e,
  input  logic load_n,
  input  logic is_init_done,
  input  logic is_multiplication_done,
  input  logic result_ack,
  output logic initialize,
  output logic en_multiply,
  output logic en_modulo,
  output logic done,
  output logic update_e,
  output logic update_n,
  output logic busy,
  output logic result_valid,
  output logic error
);

  localparam int              TW         = $clog2(INIT_TIMEOUT + 1);
  localparam logic [8:0]      MULT_LIMIT = 9'(MAX_MULT);
  localparam logic [TW-1:0]   WAIT_LAST  = TW'(INIT_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_INIT, S_SYNC, S_WAIT_INIT, S_CHECK,
    S_MULT, S_MOD, S_DONE, S_HOLD, S_ERROR
  } state_e;

  state_e        state_q, state_d;
  logic [8:0]    mult_cnt_q, mult_cnt_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          ld_e_q, ld_e_d, ld_n_q, ld_n_d;
  logic          init_q, init_d, mul_q, mul_d, mod_q, mod_d, done_q, done_d;
  logic          upd_e_q, upd_e_d, upd_n_q, upd_n_d;
  logic          busy_q, busy_d, rv_q, rv_d, err_q, err_d;

  always_comb begin
    state_d    = state_q;
    mult_cnt_d = mult_cnt_q;
    wait_cnt_d = wait_cnt_q;
    ld_e_d     = ld_e_q;
    ld_n_d     = ld_n_q;
    case (state_q)
      S_IDLE: begin
        // a load request pre-empts a simultaneous start, which is dropped
        if (load_e || load_n) begin
          state_d = S_LOAD;
          ld_e_d  = load_e;
          ld_n_d  = load_n;
        end else if (start) begin
          state_d = S_INIT;
        end
      end
      S_LOAD: state_d = S_IDLE;
      S_INIT: begin
        mult_cnt_d = '0;
        state_d    = S_SYNC;
      end
      S_SYNC: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT_INIT;
      end
      S_WAIT_INIT: begin
        if (is_init_done)                state_d = S_CHECK;
        else if (wait_cnt_q == WAIT_LAST) state_d = S_ERROR;
        else                             wait_cnt_d = wait_cnt_q + TW'(1);
      end
      S_CHECK: begin
        if (is_multiplication_done)       state_d = S_DONE;
        else if (mult_cnt_q == MULT_LIMIT) state_d = S_ERROR;
        else                              state_d = S_MULT;
      end
      S_MULT: begin
        mult_cnt_d = mult_cnt_q + 9'd1;
        state_d    = S_MOD;
      end
      S_MOD:   state_d = S_CHECK;
      S_DONE:  state_d = S_HOLD;
      S_HOLD:  if (result_ack) state_d = S_IDLE;
      S_ERROR: if (result_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // outputs are registered copies of the decode of the next state
    init_d  = (state_d == S_INIT);
    mul_d   = (state_d == S_MULT);
    mod_d   = (state_d == S_MOD);
    done_d  = (state_d == S_DONE);
    upd_e_d = (state_d == S_LOAD) && ld_e_d;
    upd_n_d = (state_d == S_LOAD) && ld_n_d;
    busy_d  = (state_d != S_IDLE);
    rv_d    = (state_d == S_HOLD);
    err_d   = (state_d == S_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mult_cnt_q <= '0;
      wait_cnt_q <= '0;
      ld_e_q     <= 1'b0;
      ld_n_q     <= 1'b0;
      init_q     <= 1'b0;
      mul_q      <= 1'b0;
      mod_q      <= 1'b0;
      done_q     <= 1'b0;
      upd_e_q    <= 1'b0;
      upd_n_q    <= 1'b0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mult_cnt_q <= mult_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      ld_e_q     <= ld_e_d;
      ld_n_q     <= ld_n_d;
      init_q     <= init_d;
      mul_q      <= mul_d;
      mod_q      <= mod_d;
      done_q     <= done_d;
      upd_e_q    <= upd_e_d;
      upd_n_q    <= upd_n_d;
      busy_q     <= busy_d;
      rv_q       <= rv_d;
      err_q      <= err_d;
    end
  end

  assign initialize   = init_q;
  assign en_multiply  = mul_q;
  assign en_modulo    = mod_q;
  assign done         = done_q;
  assign update_e     = upd_e_q;
  assign update_n     = upd_n_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign error        = err_q;

endmodule

// File: tb/tb_rsa_controller.sv
// Bench for rsa_controller: a small datapath model drives the flags, and each run is
// checked cycle by cycle against an expected output timeline built from exponent and init delay.
module tb_rsa_controller;

  logic clk = 1'b0;
  logic reset, start, load_e, load_n, is_init_done, is_multiplication_done, result_ack;
  logic initialize, en_multiply, en_modulo, done, update_e, update_n, busy, result_valid, error;

  always #5 clk = ~clk;

  rsa_controller #(.MAX_MULT(256), .INIT_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .load_e(load_e), .load_n(load_n),
    .is_init_done(is_init_done), .is_multiplication_done(is_multiplication_done),
    .result_ack(result_ack), .initialize(initialize), .en_multiply(en_multiply),
    .en_modulo(en_modulo), .done(done), .update_e(update_e), .update_n(update_n),
    .busy(busy), .result_valid(result_valid), .error(error)
  );

  localparam logic [8:0] B_INIT = 9'h100, B_MUL = 9'h080, B_MOD = 9'h040, B_DONE = 9'h020;
  localparam logic [8:0] B_UE = 9'h010, B_UN = 9'h008, B_BUSY = 9'h004, B_RV = 9'h002;
  localparam logic [8:0] B_ERR = 9'h001;

  // datapath model: exponent register, init-delay timer and multiply tally
  int   e_reg = 17, bus = 17, init_delay = 1, age = 0, mseen = 0;
  logic armed = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      armed <= 1'b0;
      age   <= 0;
      mseen <= 0;
    end else begin
      if (update_e) e_reg <= bus;
      if (initialize) begin
        armed <= 1'b1;
        age   <= 0;
        mseen <= 0;
      end else begin
        if (armed) age <= age + 1;
        if (en_multiply) mseen <= mseen + 1;
      end
    end
  end

  assign is_init_done           = armed && (age >= init_delay);
  assign is_multiplication_done = armed && (mseen == e_reg - 1);

  int checks = 0, errors = 0;
  int cyc, n_mult, done_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [8:0] obs();
    return {initialize, en_multiply, en_modulo, done, update_e, update_n, busy, result_valid, error};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (en_multiply) n_mult++;
    if (done) done_cyc = cyc;
  endtask

  task automatic clear_inputs();
    start = 1'b0; load_e = 1'b0; load_n = 1'b0; result_ack = 1'b0;
  endtask

  task automatic do_reset_abort();
    reset = 1'b1;
    start = 1'($urandom % 2);
    load_e = 1'($urandom % 2);
    result_ack = 1'($urandom % 2);
    step();
    check_eq("reset_outputs", 32'(obs()), 32'h0);
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic do_load(input int val, input bit le, input bit ln, input bit st);
    bus = val; load_e = le; load_n = ln; start = st;
    cyc = 0;
    step();
    clear_inputs();
    check_eq("load_strobe", 32'(obs()), 32'((le ? B_UE : 9'h0) | (ln ? B_UN : 9'h0) | B_BUSY));
    step();
    check_eq("load_idle", 32'(obs()), 32'h0);
  endtask

  // e: exponent already loaded, d: init-flag delay, h: extra HOLD/ERROR cycles before ack,
  // abort_at: cycle in which reset is asserted (0 = none)
  task automatic run_encrypt(input int e, input int d, input int h, input int abort_at);
    logic [8:0] q[$];
    logic [8:0] term;
    bit ok_path;
    q.delete();
    init_delay = d;
    q.push_back(B_INIT | B_BUSY);
    q.push_back(B_BUSY);
    ok_path = (d <= 8);
    if (!ok_path) begin
      for (int i = 0; i < 8; i++) q.push_back(B_BUSY);
      q.push_back(B_ERR | B_BUSY);
    end else begin
      for (int i = 0; i < d; i++) q.push_back(B_BUSY);
      for (int k = 0; ; k++) begin
        q.push_back(B_BUSY);
        if (k == e - 1) begin
          q.push_back(B_DONE | B_BUSY);
          q.push_back(B_RV | B_BUSY);
          break;
        end else if (k == 256) begin
          q.push_back(B_ERR | B_BUSY);
          break;
        end
        q.push_back(B_MUL | B_BUSY);
        q.push_back(B_MOD | B_BUSY);
      end
    end
    term = q[q.size() - 1];
    cyc = 0; n_mult = 0; done_cyc = -1;
    clear_inputs();
    start = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      step();
      check_eq("trace", 32'(obs()), 32'(q[i]));
      if (cyc == abort_at) begin
        do_reset_abort();
        return;
      end
      start  = 1'($urandom % 2);
      load_e = 1'($urandom % 2);
      load_n = 1'($urandom % 2);
      result_ack = (i < q.size() - 1) ? 1'($urandom % 2) : 1'b0;
    end
    for (int j = 0; j < h; j++) begin
      step();
      check_eq("terminal_hold", 32'(obs()), 32'(term));
      if (cyc == abort_at) begin
        do_reset_abort();
        return;
      end
      start = 1'($urandom % 2);
      load_e = 1'($urandom % 2);
      result_ack = 1'b0;
    end
    clear_inputs();
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    check_eq("ack_to_idle", 32'(obs()), 32'h0);
    if (ok_path && e - 1 <= 256) begin
      check_eq("mult_pulses", 32'(n_mult), 32'(e - 1));
      if (d == 1) check_eq("done_cycle", 32'(done_cyc), 32'(4 + 3 * (e - 1) + 1));
    end else if (ok_path) begin
      check_eq("mult_pulses_limit", 32'(n_mult), 32'd256);
    end
  endtask

  task automatic load_and_run(input int e, input int d, input int h, input int abort_at);
    do_load(e, 1'b1, 1'($urandom % 2), 1'b0);
    run_encrypt(e, d, h, abort_at);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    cyc = 0;
    step();
    step();
    check_eq("reset_state", 32'(obs()), 32'h0);
    start = 1'b1; load_e = 1'b1; load_n = 1'b1;
    step();
    check_eq("reset_priority", 32'(obs()), 32'h0);
    reset = 1'b0;
    clear_inputs();
    step();
    check_eq("idle_after_reset", 32'(obs()), 32'h0);

    do_load(17, 1'b1, 1'b1, 1'b0);
    run_encrypt(17, 1, 3, 0);
    do_load(1, 1'b1, 1'b0, 1'b1);
    run_encrypt(1, 1, 0, 0);
    load_and_run(5, 9, 1, 0);
    load_and_run(5, 8, 0, 0);
    load_and_run(17, 1, 0, 18);
    run_encrypt(17, 1, 1, 0);
    load_and_run(3, 1, 3, 13);
    load_and_run(4, 10, 3, 12);
    load_and_run(257, 1, 0, 0);
    load_and_run(258, 1, 1, 0);
    for (int n = 0; n < 20; n++)
      load_and_run(1 + int'($urandom % 30), 1 + int'($urandom % 10), int'($urandom % 4), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
